// File: rtl/vector_lsu_if.sv
// Bus bundle between a vector load/store unit, its requester, the byte-wide
// data memory and the vector register-file write port.
interface vector_lsu_if #(
    parameter int LANES = 6,
    parameter int DW    = 8,
    parameter int AW    = 16
);
    logic                       start;
    logic                       is_load;
    logic [AW-1:0]              base_addr;
    logic [3:0]                 rd_reg;
    logic [LANES-1:0][DW-1:0]   st_data;

    logic [AW-1:0]              mem_addr;
    logic                       mem_we;
    logic [DW-1:0]              mem_wdata;
    logic [DW-1:0]              mem_rdata;

    logic                       WE3;
    logic [3:0]                 A3;
    logic [LANES-1:0][DW-1:0]   WD3;

    logic                       busy;
    logic                       done;

    modport slave (
        input  start, is_load, base_addr, rd_reg, st_data, mem_rdata,
        output mem_addr, mem_we, mem_wdata, WE3, A3, WD3, busy, done
    );

    modport master (
        output start, is_load, base_addr, rd_reg, st_data, mem_rdata,
        input  mem_addr, mem_we, mem_wdata, WE3, A3, WD3, busy, done
    );
endinterface

// File: rtl/vector_lsu.sv
// Vector load/store unit: moves LANES bytes between a byte-wide data memory
// and one vector register, one lane per cycle, with registered outputs.
module vector_lsu #(
    parameter int LANES = 6,
    parameter int DW    = 8,
    parameter int AW    = 16
) (
    input  logic         clk,
    input  logic         rst,
    vector_lsu_if.slave  bus
);
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IW-1:0] LAST = IW'(LANES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE,
        LD_DRAIN,
        LD_WB,
        ST_ISSUE,
        ST_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              i_q, i_d;
    logic [AW-1:0]              base_q, base_d;
    logic [3:0]                 rd_q, rd_d;
    logic [LANES-1:0][DW-1:0]   st_q, st_d;
    logic [LANES-1:0][DW-1:0]   buf_q, buf_d;

    logic [AW-1:0]              mem_addr_q, mem_addr_d;
    logic                       mem_we_q, mem_we_d;
    logic [DW-1:0]              mem_wdata_q, mem_wdata_d;
    logic                       we3_q, we3_d;
    logic [3:0]                 a3_q, a3_d;
    logic [LANES-1:0][DW-1:0]   wd3_q, wd3_d;
    logic                       done_q, done_d;

    // Lane address wraps naturally at 2^AW through the truncating return type.
    function automatic logic [AW-1:0] lane_addr(input logic [AW-1:0] base,
                                                input logic [IW-1:0] lane);
        return base + AW'(lane);
    endfunction

    // Outputs are registered one cycle ahead: the *_d values describe the
    // lane the bus shows in the cycle after the current edge.
    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        base_d      = base_q;
        rd_d        = rd_q;
        st_d        = st_q;
        buf_d       = buf_q;
        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_wdata_d = '0;
        we3_d       = 1'b0;
        a3_d        = '0;
        wd3_d       = '0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    base_d     = bus.base_addr;
                    rd_d       = bus.rd_reg;
                    st_d       = bus.st_data;
                    i_d        = '0;
                    mem_addr_d = bus.base_addr;
                    if (bus.is_load) begin
                        state_d = LD_ISSUE;
                    end else begin
                        state_d     = ST_ISSUE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = bus.st_data[0];
                    end
                end
            end

            LD_ISSUE: begin
                // Read data arrives one cycle late, so it belongs to lane i-1.
                if (i_q != '0) begin
                    buf_d[i_q - IW'(1)] = bus.mem_rdata;
                end
                if (i_q == LAST) begin
                    state_d = LD_DRAIN;
                    i_d     = '0;
                end else begin
                    i_d        = i_q + IW'(1);
                    mem_addr_d = lane_addr(base_q, i_q + IW'(1));
                end
            end

            LD_DRAIN: begin
                buf_d[LANES-1] = bus.mem_rdata;
                state_d        = LD_WB;
                we3_d          = 1'b1;
                a3_d           = rd_q;
                wd3_d          = buf_d;
                done_d         = 1'b1;
            end

            LD_WB: begin
                state_d = IDLE;
            end

            ST_ISSUE: begin
                if (i_q == LAST) begin
                    state_d = ST_DONE;
                    i_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    i_d         = i_q + IW'(1);
                    mem_we_d    = 1'b1;
                    mem_addr_d  = lane_addr(base_q, i_q + IW'(1));
                    mem_wdata_d = st_q[i_q + IW'(1)];
                end
            end

            ST_DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            base_q      <= '0;
            rd_q        <= '0;
            st_q        <= '0;
            buf_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            we3_q       <= 1'b0;
            a3_q        <= '0;
            wd3_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            base_q      <= base_d;
            rd_q        <= rd_d;
            st_q        <= st_d;
            buf_q       <= buf_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            we3_q       <= we3_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
            done_q      <= done_d;
        end
    end

    // Side-effecting strobes are masked by rst so an abort stops them in the
    // very cycle reset is asserted, not one cycle later.
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q & ~rst;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.WE3       = we3_q & ~rst;
    assign bus.A3        = a3_q;
    assign bus.WD3       = wd3_q;
    assign bus.done      = done_q & ~rst;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_vector_lsu.sv
// Randomised scoreboard bench for vector_lsu: a driver predicts memory writes,
// register writebacks and done pulses; a negedge monitor pops and compares.
module tb_vector_lsu;
  localparam int LANES = 6;
  localparam int DW    = 8;
  localparam int AW    = 16;

  localparam int KW = 0;  // memory byte write
  localparam int KB = 1;  // register writeback
  localparam int KD = 2;  // done pulse

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] addr;
    logic [47:0] data;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;

  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;

  ev_t        expq[$];
  logic [7:0] mem[int];
  logic [7:0] ref_mem[int];

  vector_lsu_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus ();

  vector_lsu #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] dflt(input int a);
    return 8'((a * 37) ^ (a >> 8) ^ 8'h5A);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : dflt(int'(a));
  endfunction

  // Byte memory with one-cycle read latency
  always @(posedge clk) begin
    bus.mem_rdata <= mem.exists(int'(bus.mem_addr)) ? mem[int'(bus.mem_addr)]
                                                     : dflt(int'(bus.mem_addr));
    if (pre_we) mem[int'(pre_addr)] = pre_data;
    else if (bus.mem_we) mem[int'(bus.mem_addr)] = bus.mem_wdata;
  end

  task automatic check_ev(input int kind, input string nm,
                          input logic [15:0] a, input logic [47:0] d);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected cyc=%0d got addr=%h data=%h required no event",
               nm, cyc, a, d);
      return;
    end
    e = expq.pop_front();
    if (e.kind != kind || e.cyc != cyc || e.addr != a || e.data != d) begin
      errors++;
      $display("FAIL %s got kind=%0d cyc=%0d addr=%h data=%h required kind=%0d cyc=%0d addr=%h data=%h",
               nm, kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.mem_we && bus.WE3) begin
        checks++;
        errors++;
        $display("FAIL we_exclusive cyc=%0d got mem_we=1 WE3=1 required not both", cyc);
      end
      if (bus.mem_we) check_ev(KW, "mem_write", bus.mem_addr, 48'(bus.mem_wdata));
      if (bus.WE3)    check_ev(KB, "reg_writeback", 16'(bus.A3), bus.WD3);
      if (bus.done)   check_ev(KD, "done", 16'h0, 48'h0);
      if (!bus.busy) begin
        checks++;
        if (bus.mem_addr != 0 || bus.mem_wdata != 0 || bus.A3 != 0 || bus.WD3 != 0 ||
            bus.mem_we || bus.WE3 || bus.done) begin
          errors++;
          $display("FAIL idle_zero cyc=%0d got addr=%h wdata=%h A3=%h WD3=%h we=%b WE3=%b done=%b required all 0",
                   cyc, bus.mem_addr, bus.mem_wdata, bus.A3, bus.WD3, bus.mem_we, bus.WE3, bus.done);
        end
      end
    end
  end

  function automatic ev_t mk(input int kind, input int c, input logic [15:0] a,
                             input logic [47:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
    return e;
  endfunction

  // Called one time unit after a rising edge in an idle cycle; returns at the
  // same point of the first cycle the unit reports idle again.
  task automatic issue(input bit ld, input logic [15:0] base, input logic [3:0] rd,
                       input logic [47:0] sd, input int stray, input int rst_at);
    int          t;
    int          exp_idle;
    int          idle_at;
    logic [47:0] ld_data;
    logic [15:0] a;
    t = cyc;
    bus.start = 1'b1; bus.is_load = ld; bus.base_addr = base;
    bus.rd_reg = rd; bus.st_data = sd;
    if (ld) begin
      for (int k = 0; k < LANES; k++) begin
        a = base + 16'(k);
        ld_data[8*k +: 8] = ref_rd(a);
      end
      if (rst_at < 0) begin
        expq.push_back(mk(KB, t + 8, 16'(rd), ld_data));
        expq.push_back(mk(KD, t + 8, 16'h0, 48'h0));
      end
      exp_idle = (rst_at < 0) ? 9 : rst_at + 1;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (rst_at < 0 || 1 + k < rst_at) begin
          a = base + 16'(k);
          expq.push_back(mk(KW, t + 1 + k, a, 48'(sd[8*k +: 8])));
          ref_mem[int'(a)] = sd[8*k +: 8];
        end
      end
      if (rst_at < 0) expq.push_back(mk(KD, t + 7, 16'h0, 48'h0));
      exp_idle = (rst_at < 0) ? 8 : rst_at + 1;
    end
    idle_at = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (!bus.busy) begin
        idle_at = c;
        bus.start = 1'b0;
        rst = 1'b0;
        break;
      end
      bus.start     = (c == stray);
      bus.is_load   = 1'($urandom);
      bus.base_addr = 16'($urandom);
      bus.rd_reg    = 4'($urandom);
      bus.st_data   = {16'($urandom), 32'($urandom)};
      rst           = (c == rst_at);
    end
    checks++;
    if (idle_at != exp_idle) begin
      errors++;
      $display("FAIL busy_length op@%0d got idle after %0d cycles required %0d",
               t, idle_at, exp_idle);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got no finish required finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] b;
    cyc = 0; checks = 0; errors = 0; mon_en = 1'b0;
    rst = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.start = 1'b0; bus.is_load = 1'b0; bus.base_addr = '0;
    bus.rd_reg = '0; bus.st_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy || bus.done || bus.mem_we || bus.WE3 || bus.mem_addr != 0 ||
        bus.mem_wdata != 0 || bus.A3 != 0 || bus.WD3 != 0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b we=%b WE3=%b addr=%h required all 0",
               bus.busy, bus.done, bus.mem_we, bus.WE3, bus.mem_addr);
    end
    for (int k = 0; k < LANES; k++) begin
      pre_we = 1'b1; pre_addr = 16'h0100 + 16'(k); pre_data = 8'h11 * 8'(k + 1);
      ref_mem[int'(pre_addr)] = pre_data;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;
    rst = 1'b0;
    mon_en = 1'b1;

    issue(1'b1, 16'h0100, 4'd3, 48'h0, -1, -1);                   // directed load
    gap(2);
    issue(1'b0, 16'h0200, 4'd0, 48'hA5A4A3A2A1A0, -1, -1);        // directed store
    issue(1'b1, 16'h0200, 4'd9, 48'h0, -1, -1);                   // read it back
    gap(1);
    issue(1'b1, 16'hFFFE, 4'd7, 48'h0, -1, -1);                   // wrapping load
    issue(1'b0, 16'hFFFD, 4'd0, 48'h0F0E0D0C0B0A, -1, -1);        // wrapping store
    issue(1'b1, 16'hFFFD, 4'd1, 48'h0, -1, -1);
    gap(1);
    issue(1'b1, 16'h0100, 4'd3, 48'h0, 3, -1);                    // start while busy
    gap(1);
    issue(1'b0, 16'h0300, 4'd0, 48'h665544332211, -1, 3);         // aborted store
    issue(1'b1, 16'h0300, 4'd2, 48'h0, -1, -1);
    issue(1'b0, 16'h0400, 4'd0, 48'hDEADBEEFCAFE, -1, -1);        // back-to-back
    issue(1'b1, 16'h0400, 4'd15, 48'h0, -1, -1);

    for (int n = 0; n < 40; n++) begin
      b = (n % 5 == 0) ? 16'hFFFA + 16'($urandom_range(0, 5)) : 16'($urandom);
      issue(1'($urandom), b, 4'($urandom), {16'($urandom), 32'($urandom)},
            ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : -1, -1);
      gap($urandom_range(0, 2));
    end

    gap(3);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL leftover_events got %0d pending required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_lsu.md
VECTOR_LSU -- requirements
Module: vector_lsu

Interface
REQ-001 Parameter LANES, default 6, number of vector lanes.
REQ-002 Parameter DW, default 8, bits per lane.
REQ-003 Parameter AW, default 16, data-memory byte address width.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request pulse, accepted only in IDLE.
REQ-007 is_load  input  1  1 = vector load, 0 = vector store; sampled at acceptance.
REQ-008 base_addr  input  AW  address of lane 0; sampled at acceptance.
REQ-009 rd_reg  input  4  destination vector register for loads; sampled at acceptance.
REQ-010 st_data  input  [LANES-1:0][DW-1:0]  store operand, typically a register-file read port output; sampled at acceptance.
REQ-011 mem_addr  output  AW  byte address to data memory.
REQ-012 mem_we  output  1  byte write enable.
REQ-013 mem_wdata  output  DW  byte write data.
REQ-014 mem_rdata  input  DW  read data, valid exactly one cycle after mem_addr is presented.
REQ-015 WE3  output  1  register-file write enable.
REQ-016 A3  output  4  register-file write address.
REQ-017 WD3  output  [LANES-1:0][DW-1:0]  register-file write data.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 done  output  1  one-cycle completion pulse.

Function
REQ-020 FSM states SHALL be IDLE, LD_ISSUE, LD_DRAIN, LD_WB, ST_ISSUE and ST_DONE.
REQ-021 In IDLE with start=1, the block SHALL latch the operands and go to LD_ISSUE if is_load=1, else to ST_ISSUE.
REQ-022 start SHALL be ignored while busy=1, and the latched operands SHALL NOT change until the next acceptance.
REQ-023 A lane counter i SHALL run 0..LANES-1, one step per cycle, in both ISSUE states.
REQ-024 Lane i address SHALL be (base + i) mod 2^AW, so a lane past the top address wraps to 0.
REQ-025 In LD_ISSUE: mem_addr = lane i address and mem_we=0; after i=LANES-1 the next state SHALL be LD_DRAIN.
REQ-026 mem_rdata SHALL be captured into buffer lane i-1 during LD_ISSUE (i>=1), and into lane LANES-1 during LD_DRAIN.
REQ-027 LD_WB SHALL last one cycle with WE3=1, A3 = latched rd_reg, WD3 = buffer and done=1, then go to IDLE.
REQ-028 In ST_ISSUE: mem_we=1, mem_addr = lane i address, mem_wdata = latched st_data lane i; after i=LANES-1 the next state SHALL be ST_DONE.
REQ-029 ST_DONE SHALL last one cycle with done=1, mem_we=0 and WE3=0, then go to IDLE.
REQ-030 For start accepted at the edge ending cycle T, load timing SHALL be: addresses in T+1..T+6, WE3/done in T+8, IDLE in T+9.
REQ-031 For start accepted at the edge ending cycle T, store timing SHALL be: writes in T+1..T+6, done in T+7, IDLE in T+8.
REQ-032 Lane 0 SHALL map to WD3[0] and st_data[0] at the lowest address.
REQ-033 WE3 and mem_we SHALL never both be 1 in the same cycle.
REQ-034 WE3 SHALL be 1 only in LD_WB, and mem_we only in ST_ISSUE.
REQ-035 Outside the active states, mem_addr, mem_wdata, A3 and WD3 SHALL be 0.

Reset
REQ-036 When rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter, buffer and latched operands; every output SHALL be 0 on the next cycle.
REQ-037 rst SHALL take priority over start in the same cycle.
REQ-038 rst during any active state SHALL abort the operation: no further mem_we, no WE3 and no done.

Verification
REQ-039 Load: memory[0x0100..0x0105] = 11,22,33,44,55,66; start, is_load=1, base=0x0100, rd_reg=3 -> in T+8 exactly one WE3 with A3=3, WD3 = 0x665544332211 and done=1.
REQ-040 Store: st_data = 0xA5A4A3A2A1A0, base=0x0200 -> mem_we in T+1..T+6 writing A0..A5 to 0x0200..0x0205, done in T+7, WE3 never 1.
REQ-041 Wrap: load with base=0xFFFE -> addresses FFFE, FFFF, 0000, 0001, 0002, 0003.
REQ-042 Busy start: second start pulse at T+3 of a load -> ignored; same result as REQ-039 and only one done.
REQ-043 Reset mid-store: rst asserted in T+3 -> only two bytes written, all outputs 0 from T+4, no done; a subsequent load completes normally.
REQ-044 Back-to-back: start in the cycle after done, with busy=0 -> accepted, and the new operation follows the same timing.
